// File: rtl/mtimer_pkg.sv
// Shared constants for the machine timer block and the CSR unit it feeds:
// register offsets, bus FSM encoding, reset constants and the offset decoder.
package mtimer_pkg;

   localparam logic [31:0] OFF_MTIME_LO    = 32'h0000_0000;
   localparam logic [31:0] OFF_MTIME_HI    = 32'h0000_0004;
   localparam logic [31:0] OFF_MTIMECMP_LO = 32'h0000_0008;
   localparam logic [31:0] OFF_MTIMECMP_HI = 32'h0000_000C;
   localparam logic [31:0] OFF_MSIP        = 32'h0000_0010;
   localparam logic [31:0] OFF_PRESCALE    = 32'h0000_0014;
   localparam logic [31:0] OFF_MTIME_SNAP  = 32'h0000_0018;

   localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RESP = 1'b1;

   // CSR addresses and mip bit positions the interrupt outputs land on
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MIP     = 12'h344;
   localparam int          MIP_MSIP_BIT = 3;
   localparam int          MIP_MTIP_BIT = 7;

   typedef enum logic [2:0] {
      SEL_MTIME_LO,
      SEL_MTIME_HI,
      SEL_CMP_LO,
      SEL_CMP_HI,
      SEL_MSIP,
      SEL_PRESCALE,
      SEL_SNAP,
      SEL_NONE
   } reg_sel_e;

   function automatic reg_sel_e decode_offset(input logic [31:0] off);
      case (off)
         OFF_MTIME_LO:    return SEL_MTIME_LO;
         OFF_MTIME_HI:    return SEL_MTIME_HI;
         OFF_MTIMECMP_LO: return SEL_CMP_LO;
         OFF_MTIMECMP_HI: return SEL_CMP_HI;
         OFF_MSIP:        return SEL_MSIP;
         OFF_PRESCALE:    return SEL_PRESCALE;
         OFF_MTIME_SNAP:  return SEL_SNAP;
         default:         return SEL_NONE;
      endcase
   endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Clock divider for mtime: tick is high on the cycle pre_cnt equals PRESCALE,
// after which the count restarts at zero. A clear strobe restarts it early.
module mtimer_prescaler (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [15:0] prescale_i,
   input  logic        clr_i,
   output logic        tick_o
);

   logic [15:0] pre_cnt_q;
   logic [15:0] pre_cnt_d;

   assign tick_o = (pre_cnt_q == prescale_i);

   always_comb begin
      pre_cnt_d = pre_cnt_q + 16'd1;
      if (clr_i || tick_o) begin
         pre_cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pre_cnt_q <= '0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
      end
   end

endmodule

// File: rtl/mtimer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, MSIP and a prescaled
// time base behind a two-state request/response bus slave.
module mtimer
   import mtimer_pkg::*;
#(
   parameter int          ADDR_W       = 5,
   parameter logic [15:0] PRESCALE_RST = 16'h0000
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              bus_valid,
   input  logic              bus_write,
   input  logic [ADDR_W-1:0] bus_addr,
   input  logic [31:0]       bus_wdata,
   output logic              bus_ready,
   output logic [31:0]       bus_rdata,
   output logic              bus_err,
   output logic              tmr_intr_out,
   output logic              sw_intr_out
);

   logic [0:0]  state_q, state_d;
   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic        msip_q, msip_d;
   logic [15:0] prescale_q, prescale_d;
   logic [31:0] snap_q, snap_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        tmr_q;

   logic [31:0] byte_off;
   reg_sel_e    sel;
   logic        accept;
   logic        bad;
   logic        wr_en;
   logic        rd_en;
   logic        tick;
   logic        pre_clr;
   logic [31:0] rd_mux;

   // Low two address bits are masked rather than sliced off
   assign byte_off = 32'(bus_addr) & ~32'h3;
   assign sel      = decode_offset(byte_off);
   assign accept   = (state_q == ST_IDLE) && bus_valid;
   assign bad      = (sel == SEL_NONE) || (bus_write && (sel == SEL_SNAP));
   assign wr_en    = accept && bus_write && !bad;
   assign rd_en    = accept && !bus_write;
   assign pre_clr  = wr_en && (sel == SEL_PRESCALE);

   mtimer_prescaler u_prescaler (
      .clk_i      (clock),
      .rst_ni     (rst_n),
      .prescale_i (prescale_q),
      .clr_i      (pre_clr),
      .tick_o     (tick)
   );

   always_comb begin
      state_d = ST_IDLE;
      case (state_q)
         ST_IDLE: state_d = bus_valid ? ST_RESP : ST_IDLE;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rd_mux = '0;
      case (sel)
         SEL_MTIME_LO: rd_mux = mtime_q[31:0];
         SEL_MTIME_HI: rd_mux = mtime_q[63:32];
         SEL_CMP_LO:   rd_mux = mtimecmp_q[31:0];
         SEL_CMP_HI:   rd_mux = mtimecmp_q[63:32];
         SEL_MSIP:     rd_mux = {31'd0, msip_q};
         SEL_PRESCALE: rd_mux = {16'd0, prescale_q};
         SEL_SNAP:     rd_mux = snap_q;
         default:      rd_mux = '0;
      endcase
   end

   // A software write to either mtime half overrides that cycle's tick
   always_comb begin
      mtime_d = mtime_q;
      if (wr_en && (sel == SEL_MTIME_LO)) begin
         mtime_d[31:0] = bus_wdata;
      end else if (wr_en && (sel == SEL_MTIME_HI)) begin
         mtime_d[63:32] = bus_wdata;
      end else if (tick) begin
         mtime_d = mtime_q + 64'd1;
      end
   end

   always_comb begin
      mtimecmp_d = mtimecmp_q;
      msip_d     = msip_q;
      prescale_d = prescale_q;
      if (wr_en) begin
         case (sel)
            SEL_CMP_LO:   mtimecmp_d[31:0]  = bus_wdata;
            SEL_CMP_HI:   mtimecmp_d[63:32] = bus_wdata;
            SEL_MSIP:     msip_d            = bus_wdata[0];
            SEL_PRESCALE: prescale_d        = bus_wdata[15:0];
            default:      ;
         endcase
      end
   end

   always_comb begin
      snap_d  = snap_q;
      rdata_d = '0;
      err_d   = accept && bad;
      if (rd_en) begin
         rdata_d = rd_mux;
         if (sel == SEL_MTIME_LO) begin
            snap_d = mtime_q[63:32];
         end
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         mtime_q    <= '0;
         mtimecmp_q <= MTIMECMP_RST;
         msip_q     <= 1'b0;
         prescale_q <= PRESCALE_RST;
         snap_q     <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         tmr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         msip_q     <= msip_d;
         prescale_q <= prescale_d;
         snap_q     <= snap_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         tmr_q      <= (mtime_q >= mtimecmp_q);
      end
   end

   assign bus_ready    = (state_q == ST_RESP);
   assign bus_rdata    = bus_ready ? rdata_q : 32'd0;
   assign bus_err      = bus_ready && err_q;
   assign tmr_intr_out = tmr_q;
   assign sw_intr_out  = msip_q;

   a_ready_single : assert property (@(posedge clock) disable iff (!rst_n)
      bus_ready |=> !bus_ready);

endmodule

// File: tb/tb_mtimer.sv
// Directed bench for mtimer: reset state, prescaled counting, compare
// interrupt, carry/snapshot atomicity, error decode and reset mid-response.
module tb_mtimer;

   localparam int AW = 6;

   logic          clock = 1'b0;
   logic          rst_n = 1'b0;
   logic          bus_valid = 1'b0;
   logic          bus_write = 1'b0;
   logic [AW-1:0] bus_addr = '0;
   logic [31:0]   bus_wdata = '0;
   logic          bus_ready;
   logic [31:0]   bus_rdata;
   logic          bus_err;
   logic          tmr_intr_out;
   logic          sw_intr_out;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int acc_cyc = 0;

   mtimer #(
      .ADDR_W       (AW),
      .PRESCALE_RST (16'h0000)
   ) dut (
      .clock        (clock),
      .rst_n        (rst_n),
      .bus_valid    (bus_valid),
      .bus_write    (bus_write),
      .bus_addr     (bus_addr),
      .bus_wdata    (bus_wdata),
      .bus_ready    (bus_ready),
      .bus_rdata    (bus_rdata),
      .bus_err      (bus_err),
      .tmr_intr_out (tmr_intr_out),
      .sw_intr_out  (sw_intr_out)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, exp);
      end
   endtask

   // One bus transaction; acc_cyc is set to the index of the accepting edge
   task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
      int n;
      @(negedge clock);
      check("idle_ready_low", bus_ready, 1'b0);
      bus_valid = 1'b1;
      bus_write = wr;
      bus_addr  = a;
      bus_wdata = wd;
      @(negedge clock);
      check("ready_latency", bus_ready, 1'b1);
      n = 0;
      while (!bus_ready && n < 8) begin
         @(negedge clock);
         n++;
      end
      acc_cyc   = cyc;
      rd        = bus_rdata;
      er        = bus_err;
      bus_valid = 1'b0;
      $display("xfer %s addr=%h wdata=%h rdata=%h err=%b edge=%0d",
               wr ? "WR" : "RD", a, wd, rd, er, acc_cyc);
   endtask

   task automatic do_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic exp_err);
      logic [31:0] rd;
      logic        er;
      xfer(1'b1, a, d, rd, er);
      check("wr_err", er, exp_err);
   endtask

   task automatic do_rd(input string tag, input logic [AW-1:0] a,
                        input logic [31:0] exp, input logic exp_err);
      logic [31:0] rd;
      logic        er;
      xfer(1'b0, a, 32'd0, rd, er);
      check(tag, rd, exp);
      check({tag, "_err"}, er, exp_err);
   endtask

   initial begin
      int p;
      int q;
      int rise;
      int rel;
      logic [31:0] rd;
      logic        er;

      // Reset state
      repeat (2) @(negedge clock);
      check("rst_ready", bus_ready, 1'b0);
      check("rst_rdata", bus_rdata, 32'd0);
      check("rst_err", bus_err, 1'b0);
      check("rst_tmr", tmr_intr_out, 1'b0);
      check("rst_sw", sw_intr_out, 1'b0);
      rst_n = 1'b1;

      // mtimecmp reset value
      do_rd("cmp_lo_rst", 6'h08, 32'hFFFF_FFFF, 1'b0);
      do_rd("cmp_hi_rst", 6'h0C, 32'hFFFF_FFFF, 1'b0);
      check("tmr_after_rst", tmr_intr_out, 1'b0);

      // PRESCALE=3: ticks land on edges P+4, P+8, ...
      do_wr(6'h14, 32'd3, 1'b0);
      p = acc_cyc;
      do_wr(6'h0C, 32'd0, 1'b0);
      do_wr(6'h08, 32'd10, 1'b0);
      do_wr(6'h04, 32'd0, 1'b0);
      do_wr(6'h00, 32'd0, 1'b0);     // edge P+8 coincides with a tick
      do_rd("pre_rd_p10", 6'h00, 32'd0, 1'b0);
      do_rd("pre_rd_p12", 6'h00, 32'd0, 1'b0);
      do_rd("pre_rd_p14", 6'h00, 32'd1, 1'b0);
      do_rd("pre_rd_p16", 6'h00, 32'd1, 1'b0);
      do_rd("pre_rd_p18", 6'h00, 32'd2, 1'b0);
      check("tmr_low_mtime2", tmr_intr_out, 1'b0);
      rise = -1;
      for (int i = 0; i < 100 && rise < 0; i++) begin
         @(negedge clock);
         if (tmr_intr_out) rise = cyc;
      end
      check("tmr_rise_edge", 64'(rise), 64'(p + 49));

      // Write at a tick edge: software value wins, no increment
      do_wr(6'h14, 32'd3, 1'b0);
      q = acc_cyc;
      do_wr(6'h04, 32'd0, 1'b0);
      do_wr(6'h00, 32'd5, 1'b0);     // edge Q+4 is a tick edge
      do_rd("sw_wins_q6", 6'h00, 32'd5, 1'b0);
      do_rd("sw_wins_q8", 6'h00, 32'd5, 1'b0);
      do_rd("sw_wins_q10", 6'h00, 32'd6, 1'b0);
      check("tmr_clr_by_mtime_wr", tmr_intr_out, 1'b0);
      check("q_ref", 64'(acc_cyc - q), 64'd10);

      // Carry into the high half and snapshot consistency
      do_wr(6'h14, 32'd0, 1'b0);
      do_wr(6'h04, 32'd0, 1'b0);
      do_wr(6'h00, 32'hFFFF_FFFF, 1'b0);
      do_rd("carry_lo", 6'h00, 32'h0000_0000, 1'b0);
      do_rd("carry_hi", 6'h04, 32'h0000_0001, 1'b0);
      do_rd("carry_snap", 6'h18, 32'h0000_0001, 1'b0);
      do_wr(6'h04, 32'd0, 1'b0);
      do_wr(6'h00, 32'hFFFF_FFFE, 1'b0);
      do_rd("atomic_lo", 6'h00, 32'hFFFF_FFFF, 1'b0);
      do_rd("atomic_snap", 6'h18, 32'h0000_0000, 1'b0);
      do_rd("atomic_hi_live", 6'h04, 32'h0000_0001, 1'b0);
      check("tmr_high_mtime", tmr_intr_out, 1'b1);

      // MSIP, read-only and unmapped offsets
      do_wr(6'h10, 32'hFFFF_FFFF, 1'b0);
      check("sw_intr_set", sw_intr_out, 1'b1);
      do_rd("msip_rd", 6'h10, 32'd1, 1'b0);
      do_wr(6'h14, 32'h0000_FFFF, 1'b0);
      do_wr(6'h00, 32'h0000_0100, 1'b0);
      do_wr(6'h20, 32'h0000_DEAD, 1'b1);
      do_wr(6'h18, 32'h0000_1234, 1'b1);
      do_rd("snap_ro", 6'h18, 32'h0000_0000, 1'b0);
      do_rd("unmapped_1c", 6'h1C, 32'h0000_0000, 1'b1);
      do_rd("lo_kept", 6'h00, 32'h0000_0100, 1'b0);
      do_rd("hi_kept", 6'h04, 32'h0000_0001, 1'b0);
      do_rd("msip_kept", 6'h10, 32'd1, 1'b0);
      do_rd("prescale_kept", 6'h14, 32'h0000_FFFF, 1'b0);
      check("sw_intr_kept", sw_intr_out, 1'b1);

      // Reset asserted during RESP of a read
      @(negedge clock);
      bus_valid = 1'b1;
      bus_write = 1'b0;
      bus_addr  = 6'h00;
      @(negedge clock);
      check("rst_mid_resp_pre", bus_ready, 1'b1);
      rst_n     = 1'b0;
      bus_valid = 1'b0;
      #1;
      check("rst_mid_ready", bus_ready, 1'b0);
      check("rst_mid_rdata", bus_rdata, 32'd0);
      check("rst_mid_tmr", tmr_intr_out, 1'b0);
      check("rst_mid_sw", sw_intr_out, 1'b0);
      repeat (2) @(negedge clock);
      rst_n = 1'b1;
      rel = cyc;
      repeat (4) begin
         @(negedge clock);
         check("no_resp_after_rst", bus_ready, 1'b0);
      end
      do_rd("rst_snap", 6'h18, 32'd0, 1'b0);
      xfer(1'b0, 6'h00, 32'd0, rd, er);
      check("rst_mtime_lo", rd, 64'(acc_cyc - rel - 1));
      do_rd("rst_mtime_hi", 6'h04, 32'd0, 1'b0);
      do_rd("rst_cmp_lo", 6'h08, 32'hFFFF_FFFF, 1'b0);
      do_rd("rst_cmp_hi", 6'h0C, 32'hFFFF_FFFF, 1'b0);
      do_rd("rst_msip", 6'h10, 32'd0, 1'b0);
      do_rd("rst_prescale", 6'h14, 32'd0, 1'b0);
      check("rst_tmr_low", tmr_intr_out, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
